// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 encodings, FSM states, iteration count and operand-class helpers.
package muldiv_pkg;

    localparam int MD_XLEN = 32;
    localparam int MD_ITER = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2,
        MD_DONE  = 2'd3
    } md_state_t;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } md_step_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic rs1_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage to multiply/divide sequencer handshake: request, operands,
// flush, and the stall/done/result return path.
interface ex_muldiv_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1_data, rs2_data, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, flush,
        output stall, done, result
    );
endinterface

// File: rtl/ex_muldiv_ctrl_step.sv
// One iteration of the shared datapath: shift-add multiply on {product_hi, multiplier}
// or restoring divide on {remainder, dividend/quotient}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  md_step_t          mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);
    logic [XLEN:0] sum_s;
    logic [XLEN:0] shifted_s;
    logic [XLEN:0] trial_s;

    assign sum_s     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    assign shifted_s = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    // shifted < 2*divisor, so bit XLEN of the 33-bit difference is exactly the borrow
    assign trial_s   = shifted_s - {1'b0, operand};

    // Select the multiply or divide iteration; the quotient bit is merged in by the caller
    always_comb begin
        acc_next = acc;
        q_bit    = 1'b0;
        case (mode)
            STEP_MUL: begin
                acc_next = {sum_s, acc[XLEN-1:1]};
                q_bit    = 1'b0;
            end
            STEP_DIV: begin
                q_bit    = ~trial_s[XLEN];
                acc_next = {(q_bit ? trial_s[XLEN-1:0] : shifted_s[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
            end
            default: begin
                acc_next = acc;
                q_bit    = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide sequencer beside the EX ALU: accepts one op per start,
// stalls the pipeline while iterating, and pulses done with a registered result.
module ex_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    ex_muldiv_ctrl_if.slave bus
);
    localparam int              CNT_W    = $clog2(MD_ITER);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_r, state_s;
    md_step_t          mode_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        op_r;
    logic              neg_a_r, neg_b_r;
    logic [2*XLEN-1:0] acc_r, step_acc_s, prod_s;
    logic [XLEN-1:0]   opnd_r, result_r;
    logic [XLEN-1:0]   rs1_mag_s, rs2_mag_s, fast_res_s, fix_res_s, quo_s, rem_s;
    logic              rs1_neg_s, rs2_neg_s, accept_s, fast_s;
    logic              div_zero_s, div_ovf_s, last_iter_s, q_bit_s;

    assign accept_s    = (state_r == MD_IDLE) & bus.start & ~bus.flush;
    assign rs1_neg_s   = rs1_signed(bus.op) & bus.rs1_data[XLEN-1];
    assign rs2_neg_s   = rs2_signed(bus.op) & bus.rs2_data[XLEN-1];
    assign rs1_mag_s   = rs1_neg_s ? (~bus.rs1_data + ONE) : bus.rs1_data;
    assign rs2_mag_s   = rs2_neg_s ? (~bus.rs2_data + ONE) : bus.rs2_data;
    assign div_zero_s  = (bus.rs2_data == ZERO);
    assign div_ovf_s   = is_div(bus.op) & rs2_signed(bus.op) &
                         (bus.rs1_data == MIN_NEG) & (bus.rs2_data == ALL_ONES);
    assign fast_s      = is_div(bus.op) & (div_zero_s | div_ovf_s);
    assign last_iter_s = (cnt_r == CNT_W'(MD_ITER - 1));
    assign mode_s      = is_div(op_r) ? STEP_DIV : STEP_MUL;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode     (mode_s),
        .acc      (acc_r),
        .operand  (opnd_r),
        .acc_next (step_acc_s),
        .q_bit    (q_bit_s)
    );

    // Divide-by-zero and signed-overflow answers, produced straight from the request
    always_comb begin
        fast_res_s = ZERO;
        case (bus.op)
            MD_DIV, MD_DIVU: fast_res_s = div_zero_s ? ALL_ONES : MIN_NEG;
            MD_REM, MD_REMU: fast_res_s = div_zero_s ? bus.rs1_data : ZERO;
            default:         fast_res_s = ZERO;
        endcase
    end

    // Sign restoration and result selection from the finished accumulator
    always_comb begin
        prod_s    = (neg_a_r ^ neg_b_r) ? (~acc_r + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_r;
        quo_s     = (neg_a_r ^ neg_b_r) ? (~acc_r[XLEN-1:0] + ONE) : acc_r[XLEN-1:0];
        rem_s     = neg_a_r ? (~acc_r[2*XLEN-1:XLEN] + ONE) : acc_r[2*XLEN-1:XLEN];
        fix_res_s = ZERO;
        case (op_r)
            MD_MUL:                       fix_res_s = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res_s = quo_s;
            MD_REM, MD_REMU:              fix_res_s = rem_s;
            default:                      fix_res_s = ZERO;
        endcase
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_s = state_r;
        if (bus.flush) begin
            state_s = MD_IDLE;
        end else begin
            case (state_r)
                MD_IDLE:  state_s = bus.start ? (fast_s ? MD_DONE : MD_CALC) : MD_IDLE;
                MD_CALC:  state_s = last_iter_s ? MD_FIXUP : MD_CALC;
                MD_FIXUP: state_s = MD_DONE;
                MD_DONE:  state_s = MD_IDLE;
                default:  state_s = MD_IDLE;
            endcase
        end
    end

    // State, operand latches, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= MD_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 3'd0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            acc_r    <= {(2*XLEN){1'b0}};
            opnd_r   <= ZERO;
            result_r <= ZERO;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                op_r    <= bus.op;
                neg_a_r <= rs1_neg_s;
                neg_b_r <= rs2_neg_s;
                cnt_r   <= {CNT_W{1'b0}};
                // Multiply iterates over the multiplier in the low half; divide over the dividend
                if (is_div(bus.op)) begin
                    acc_r  <= {ZERO, rs1_mag_s};
                    opnd_r <= rs2_mag_s;
                end else begin
                    acc_r  <= {ZERO, rs2_mag_s};
                    opnd_r <= rs1_mag_s;
                end
                if (fast_s) begin
                    result_r <= fast_res_s;
                end
            end else if ((state_r == MD_CALC) && !bus.flush) begin
                acc_r <= step_acc_s | {{(2*XLEN-1){1'b0}}, q_bit_s};
                cnt_r <= cnt_r + CNT_W'(1);
            end else if ((state_r == MD_FIXUP) && !bus.flush) begin
                result_r <= fix_res_s;
            end
        end
    end

    assign bus.stall  = rst_n & (accept_s | (state_r == MD_CALC) | (state_r == MD_FIXUP));
    assign bus.done   = (state_r == MD_DONE);
    assign bus.result = result_r;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed vector table, randomized ops
// against an arithmetic reference model, and flush/reset/ignored-start sequences.
module tb_ex_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_muldiv_ctrl_if #(.XLEN(32)) bus();

    ex_muldiv_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t        vecs[16];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] last_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa64, sb64, sp;
        logic [63:0]        up;
        int                 sa, sb;
        logic [31:0]        r;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sa   = a;
        sb   = b;
        up   = {32'd0, a} * {32'd0, b};
        r    = 32'd0;
        case (op)
            3'd0: r = up[31:0];
            3'd1: begin sp = sa64 * sb64; r = sp[63:32]; end
            3'd2: begin sp = sa64 * $signed({32'd0, b}); r = sp[63:32]; end
            3'd3: r = up[63:32];
            3'd4: r = (b == 32'd0) ? 32'hFFFFFFFF :
                      ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(sa / sb));
            3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: r = (b == 32'd0) ? a :
                      ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb));
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ovf;
        ovf = (op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF;
        return (op >= 3'd4 && (b == 32'd0 || ovf)) ? 1 : 34;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFFFFFF;
            3:       v = 32'h80000000;
            4:       v = 32'($urandom_range(0, 20));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // One operation from a fresh cycle 0; noise drives stray starts in CALC and DONE
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input bit noise,
                          input string name);
        int cyc;
        int stalls;
        bit got;
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.flush    = 1'b0;
        bus.op       = op;
        bus.rs1_data = a;
        bus.rs2_data = b;
        cyc = 0;
        stalls = 0;
        got = 1'b0;
        @(negedge clk);
        if (bus.stall) stalls++;
        while (!got && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (noise && ((cyc >= 5 && cyc <= 8) || cyc == exp_lat)) begin
                bus.start    = 1'b1;
                bus.op       = MD_DIV;
                bus.rs1_data = 32'd5;
                bus.rs2_data = 32'd0;
            end else begin
                bus.start    = 1'b0;
                bus.op       = 3'($urandom_range(0, 7));
                bus.rs1_data = $urandom();
                bus.rs2_data = $urandom();
            end
            @(negedge clk);
            if (bus.stall) stalls++;
            if (bus.done) got = 1'b1;
        end
        check({name, "_lat"}, got ? 32'(cyc) : 32'hFFFFFFFF, 32'(exp_lat));
        check({name, "_res"}, bus.result, exp_res);
        check({name, "_stalls"}, 32'(stalls), 32'(exp_lat));
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({name, "_pulse"}, 32'(bus.done), 32'd0);
        check({name, "_idle"}, 32'(bus.stall), 32'd0);
        check({name, "_hold"}, bus.result, exp_res);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit          done_seen;

        vecs[0]  = '{MD_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{MD_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
        vecs[2]  = '{MD_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
        vecs[3]  = '{MD_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 34};
        vecs[4]  = '{MD_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34};
        vecs[5]  = '{MD_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34};
        vecs[6]  = '{MD_DIVU,   32'd100,      32'd7,        32'd14,       34};
        vecs[7]  = '{MD_REMU,   32'd100,      32'd7,        32'd2,        34};
        vecs[8]  = '{MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{MD_REMU,   32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[12] = '{MD_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34};
        vecs[13] = '{MD_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
        vecs[14] = '{MD_REM,    32'd5,        32'd0,        32'd5,        1};
        vecs[15] = '{MD_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34};

        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.flush    = 1'b0;
        bus.op       = MD_DIV;
        bus.rs1_data = 32'd5;
        bus.rs2_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(bus.stall), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        last_res  = 32'd0;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b0,
                   $sformatf("vec%0d", i));
            last_res = vecs[i].res;
        end

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_op(rop, ra, rb, ref_model(rop, ra, rb), ref_lat(rop, ra, rb), 1'b0,
                   $sformatf("rnd%0d_op%0d", i, rop));
            last_res = ref_model(rop, ra, rb);
        end

        // Flush at cycle 10 of a DIVU, then a fresh op accepted at cycle 12
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.op       = MD_DIVU;
        bus.rs1_data = 32'd1000;
        bus.rs2_data = 32'd3;
        done_seen    = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.flush = (c == 10);
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        check("flush_idle_stall", 32'(bus.stall), 32'd0);
        check("flush_no_done", 32'(done_seen), 32'd0);
        check("flush_result_kept", bus.result, last_res);
        run_op(MD_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0, "after_flush");
        last_res = 32'd14;

        // flush together with start in IDLE must not accept
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.flush    = 1'b1;
        bus.op       = MD_DIV;
        bus.rs1_data = 32'd5;
        bus.rs2_data = 32'd0;
        @(negedge clk);
        check("flush_start_stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_start_no_done", 32'(bus.done), 32'd0);
        check("flush_start_result", bus.result, last_res);

        // Reset at cycle 20 of a MUL
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.op       = MD_MUL;
        bus.rs1_data = 32'd7;
        bus.rs2_data = 32'hFFFFFFFD;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (c == 20) rst_n = 1'b0;
            @(negedge clk);
        end
        check("midrst_stall_low", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_result", bus.result, 32'd0);
        check("midrst_stall", 32'(bus.stall), 32'd0);

        run_op(MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b1, "start_ignored");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
